// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// default data/address widths.
package mem_arbiter_pkg;

    localparam int DEF_MEM_WIDTH = 8;
    localparam int DEF_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: selects the first requester after the last granted
// index, wrapping modulo NUM_REQ. Purely combinational.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic found;

    // Distance k=1 is the highest priority, k=NUM_REQ (the last winner itself) the lowest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % NUM_REQ)) begin
                    winner = IDX_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port among NUM_REQ
// masters; each access takes IDLE -> ISSUE -> RESP (3 cycles).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_REQ   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [MEM_WIDTH-1:0]           rdata,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [WORD_SIZE-1:0]           mem_addr,
    output logic [MEM_WIDTH-1:0]           mem_wdata,
    input  logic [MEM_WIDTH-1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     winner;
    logic                 any_req;
    logic                 cur_we;
    logic                 sel_we;
    logic [WORD_SIZE-1:0] sel_addr;
    logic [MEM_WIDTH-1:0] sel_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*WORD_SIZE +: WORD_SIZE];
                sel_wdata = req_wdata[i*MEM_WIDTH +: MEM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            cur_we    <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        gnt       <= NUM_REQ'(1) << winner;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        cur_we    <= sel_we;
                        last      <= winner;
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // Memory samples at this edge; strobes drop, address/data hold.
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    done   <= gnt;
                    state  <= ARB_RESP;
                end
                ARB_RESP: begin
                    done  <= '0;
                    gnt   <= '0;
                    state <= ARB_IDLE;
                end
                default: begin
                    gnt    <= '0;
                    done   <= '0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

    // Registered memory data arrives during RESP; pass it straight through for reads.
    assign rdata = (state == ARB_RESP && !cur_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table vectors, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int MW = 8;
    localparam int AW = 8;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we, gnt, done;
    logic [N*AW-1:0] req_addr;
    logic [N*MW-1:0] req_wdata;
    logic [MW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [MW-1:0]   mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_WIDTH(MW), .WORD_SIZE(AW), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous memory with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_master(input int i, input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d);
        req_we[i]              = we;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*MW +: MW]  = d;
    endtask

    typedef struct {
        logic [N-1:0] rq;
        logic [N-1:0] we;
        logic [7:0]   a0, d0, a1, d1;
        int           owner;
        logic         exp_we;
        logic [7:0]   exp_addr, exp_wdata, exp_rdata;
    } vec_t;

    vec_t tbl[6];

    // Transaction-level reference: a transfer occupies 3 cycles from its start edge.
    int           m_phase, m_owner, m_last;
    logic         m_we;
    logic [AW-1:0] m_addr;
    logic [MW-1:0] m_wdata, m_rd;
    logic [MW-1:0] m_mem [256];

    task automatic model_step();
        if (rst) begin
            m_phase = 0;
            m_last  = N - 1;
        end else if (m_phase == 0) begin
            if (req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        break;
                    end
                end
                m_last  = m_owner;
                m_we    = req_we[m_owner];
                m_addr  = req_addr[m_owner*AW +: AW];
                m_wdata = req_wdata[m_owner*MW +: MW];
                if (m_we) m_mem[m_addr] = m_wdata;
                else      m_rd = m_mem[m_addr];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic model_compare();
        logic [N-1:0] onehot;
        onehot = N'(1) << m_owner;
        case (m_phase)
            1: begin
                chk("rnd_gnt_issue", gnt, onehot);
                chk("rnd_done_issue", done, 0);
                chk("rnd_mem_en_issue", mem_en, 1);
                chk("rnd_mem_we_issue", mem_we, m_we);
                chk("rnd_mem_addr", mem_addr, m_addr);
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            2: begin
                chk("rnd_gnt_resp", gnt, onehot);
                chk("rnd_done_resp", done, onehot);
                chk("rnd_mem_en_resp", mem_en, 0);
                chk("rnd_rdata_resp", rdata, m_we ? 8'h00 : m_rd);
            end
            default: begin
                chk("rnd_gnt_idle", gnt, 0);
                chk("rnd_done_idle", done, 0);
                chk("rnd_mem_en_idle", mem_en, 0);
                chk("rnd_mem_we_idle", mem_we, 0);
                chk("rnd_rdata_idle", rdata, 0);
            end
        endcase
    endtask

    task automatic new_txn(input int i);
        set_master(i, 1'($urandom_range(1, 0)), AW'($urandom_range(8'h87, 8'h80)), MW'($urandom));
    endtask

    initial begin
        int seen;
        int last_cyc;
        int cyc;
        logic [N-1:0] order[6];
        int stamp[6];

        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        tbl[0] = '{2'b01, 2'b01, 8'h10, 8'hA5, 8'h00, 8'h00, 0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1] = '{2'b10, 2'b00, 8'h00, 8'h00, 8'h10, 8'h00, 1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{2'b11, 2'b01, 8'h20, 8'h3C, 8'h10, 8'h00, 0, 1'b1, 8'h20, 8'h3C, 8'h00};
        tbl[3] = '{2'b11, 2'b10, 8'h20, 8'h00, 8'h30, 8'h5A, 1, 1'b1, 8'h30, 8'h5A, 8'h00};
        tbl[4] = '{2'b11, 2'b00, 8'h20, 8'h00, 8'h30, 8'h00, 0, 1'b0, 8'h20, 8'h00, 8'h3C};
        tbl[5] = '{2'b10, 2'b00, 8'h00, 8'h00, 8'h30, 8'h00, 1, 1'b0, 8'h30, 8'h00, 8'h5A};

        // Reset held with no requests, then released.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_done", done, 0);
            chk("rst_mem_en", mem_en, 0);
        end
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_gnt", gnt, 0);
            chk("idle_mem_en", mem_en, 0);
        end

        // Table vectors: one full transaction each, starting from IDLE.
        for (int v = 0; v < 6; v++) begin
            set_master(0, tbl[v].we[0], tbl[v].a0, tbl[v].d0);
            set_master(1, tbl[v].we[1], tbl[v].a1, tbl[v].d1);
            req = tbl[v].rq;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", v), gnt, N'(1) << tbl[v].owner);
            chk($sformatf("vec%0d_done_issue", v), done, 0);
            chk($sformatf("vec%0d_mem_en", v), mem_en, 1);
            chk($sformatf("vec%0d_mem_we", v), mem_we, tbl[v].exp_we);
            chk($sformatf("vec%0d_mem_addr", v), mem_addr, tbl[v].exp_addr);
            if (tbl[v].exp_we) chk($sformatf("vec%0d_mem_wdata", v), mem_wdata, tbl[v].exp_wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_done", v), done, N'(1) << tbl[v].owner);
            chk($sformatf("vec%0d_gnt_resp", v), gnt, N'(1) << tbl[v].owner);
            chk($sformatf("vec%0d_mem_en_resp", v), mem_en, 0);
            chk($sformatf("vec%0d_mem_we_resp", v), mem_we, 0);
            chk($sformatf("vec%0d_rdata", v), rdata, tbl[v].exp_rdata);
            req = '0;
            @(negedge clk);
        end

        // Both masters requesting continuously: strict alternation, 3-cycle spacing.
        set_master(0, 1'b0, 8'h10, 8'h00);
        set_master(1, 1'b0, 8'h20, 8'h00);
        req = 2'b11;
        seen = 0; cyc = 0; last_cyc = 0;
        while (seen < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("cont_gnt_onehot", $countones(gnt) <= 1, 1);
            if (done != 0) begin
                order[seen] = done;
                stamp[seen] = cyc;
                seen++;
            end
        end
        req = '0;
        chk("cont_done_count", seen, 6);
        for (int k = 0; k < seen; k++) begin
            chk($sformatf("cont_order%0d", k), order[k], N'(1) << (k % 2));
            if (k > 0) chk($sformatf("cont_spacing%0d", k), stamp[k] - stamp[k-1], 3);
        end
        @(negedge clk);

        // Reset during ISSUE of a master1 read.
        set_master(1, 1'b0, 8'h10, 8'h00);
        req = 2'b10;
        @(negedge clk);
        chk("rst1_gnt_before", gnt, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        chk("rst1_gnt", gnt, 0);
        chk("rst1_done", done, 0);
        chk("rst1_mem_en", mem_en, 0);
        rst = 1'b0;
        set_master(0, 1'b0, 8'h10, 8'h00);
        req = 2'b11;
        @(negedge clk);
        chk("rst1_winner", gnt, 2'b01);
        @(negedge clk);
        chk("rst1_done_after", done, 2'b01);
        req = '0;
        @(negedge clk);

        // Reset during ISSUE of master0: pointer must return to N-1 so master0 wins again.
        req = 2'b01;
        @(negedge clk);
        chk("rst0_gnt_before", gnt, 2'b01);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("rst0_gnt", gnt, 0);
        chk("rst0_done", done, 0);
        rst = 1'b0;
        req = 2'b11;
        @(negedge clk);
        chk("rst0_winner", gnt, 2'b01);
        @(negedge clk);
        req = '0;
        @(negedge clk);

        // Master0 drops req during ISSUE: transaction still completes, no regrant.
        set_master(0, 1'b1, 8'h40, 8'h77);
        req = 2'b01;
        @(negedge clk);
        chk("drop_gnt", gnt, 2'b01);
        req = '0;
        @(negedge clk);
        chk("drop_done", done, 2'b01);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("drop_no_gnt", gnt, 0);
            chk("drop_no_done", done, 0);
        end
        set_master(1, 1'b0, 8'h40, 8'h00);
        req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("drop_write_landed", rdata, 8'h77);
        req = '0;
        @(negedge clk);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 256; a++) m_mem[a] = mem[a];
        m_phase = 0; m_last = N - 1; m_owner = 0; m_we = 0; m_rd = '0;
        m_addr = '0; m_wdata = '0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            model_compare();
            for (int i = 0; i < N; i++) begin
                if (m_phase == 2 && m_owner == i) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else new_txn(i);
                end else if (m_phase == 1 && m_owner == i && $urandom_range(7, 0) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(9, 0) < 4) begin
                    new_txn(i);
                    req[i] = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous memory port (address bus, data, write enable) among NUM_REQ bus masters, e.g. the cpu core and a program loader/DMA.
- Each master has a req/done handshake.
- The arbiter picks one master by round-robin, drives the memory for one access, and returns read data with a done pulse.
- Sits between the masters and the memory model; masters never drive the memory directly.

Parameters:
- MEM_WIDTH, 8, data word width in bits
- WORD_SIZE, 8, address width in bits
- NUM_REQ, 2, number of masters (2..8)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-master access request, level, held until done
- req_we  in  NUM_REQ  per-master write (1) / read (0), stable while req high
- req_addr  in  NUM_REQ*WORD_SIZE  flattened addresses; master i at [i*WORD_SIZE +: WORD_SIZE]
- req_wdata  in  NUM_REQ*MEM_WIDTH  flattened write data, same packing
- gnt  out  NUM_REQ  one-hot, high for the whole owned transaction (ISSUE+RESP)
- done  out  NUM_REQ  one-hot single-cycle completion pulse
- rdata  out  MEM_WIDTH  read data; valid only while done is high for a read
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  WORD_SIZE  memory address
- mem_wdata  out  MEM_WIDTH  memory write data
- mem_rdata  in  MEM_WIDTH  memory read data; registered, valid the cycle after the access edge

Behaviour:
- States: IDLE, ISSUE, RESP; encoding 2 bits.
- Reset values:
  - state=IDLE
  - gnt=0, done=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - last-grant pointer = NUM_REQ-1, so master 0 wins first
  - rdata=0 whenever done is low
- IDLE:
  - If req is nonzero at the posedge, the winner is the first requesting index scanning last+1, last+2, … modulo NUM_REQ.
  - On that edge: gnt[winner]=1; mem_en=1; mem_we, mem_addr, mem_wdata registered from the winner; pointer=winner; state→ISSUE.
  - If req is zero, stay in IDLE with all outputs low.
- ISSUE:
  - Memory outputs are stable for exactly this one cycle; the memory samples at the closing edge.
  - At that edge: mem_en=0, mem_we=0 (addr/wdata may hold); done[winner]=1; state→RESP.
- RESP:
  - done[winner]=1 and gnt[winner]=1 for one cycle.
  - For a read, rdata=mem_rdata (combinational pass-through); for a write, rdata=0.
  - At the closing edge: done=0, gnt=0, state→IDLE.
- Latency: req sampled at edge k → mem_en high cycle k+1 → done high cycle k+2 → arbitration again at edge k+3.
- Throughput: one transaction per 3 cycles, regardless of master.
- Master rule: drop req (or present a new transaction) before the edge following done. A req still high when IDLE samples it is a new request.
- Req dropped during ISSUE/RESP: the transaction still completes and done still pulses; no abort.
- All masters requesting continuously: strict rotation 0,1,…,NUM_REQ-1,0.
- Sole requester: served back-to-back every 3 cycles; the pointer does not starve it.
- Request arriving during ISSUE/RESP: waits for IDLE. No preemption.
- rst mid-transaction: immediate return to reset values. No done pulse. Memory write already issued at the ISSUE edge may have completed; aborted reads are lost.
- mem_we is never high while mem_en is low.
- At most one gnt bit and one done bit are ever high.

Decomposition:
- Shared package/header: state constants ARB_IDLE=0, ARB_ISSUE=1, ARB_RESP=2; default widths MEM_WIDTH/WORD_SIZE.
- One sub-module, rr_picker: combinational. Inputs req and last pointer; outputs winner index and any_req. Parameterised by NUM_REQ.
- Muxing and the FSM stay in mem_arbiter.

Test Plan:
- Reset then idle, req=00 → gnt=00, done=00, mem_en=0 for 10 cycles; release rst → still idle.
- Master0 write: req0=1, we=1, addr=0x10, wdata=0xA5 → mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 one cycle later; done0 pulse the cycle after.
- Master1 read: addr=0x10 after the above write, memory model returns 0xA5 → rdata=0xA5 exactly while done1=1; mem_we=0 throughout.
- Both requesting continuously, 6 transactions → grant order 0,1,0,1,0,1; done spacing exactly 3 cycles; gnt always one-hot.
- rst asserted during ISSUE of a read by master1 → next cycle gnt=0, done=0, pointer reset, and master0 wins the first post-reset contention with master1.
- Master0 drops req during ISSUE → done0 still pulses once; no new grant to master0 afterwards.
